// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields and a 32-bit immediate into an instruction word,
// flags out-of-range or misaligned immediates and tags each word with its byte address.
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 addr_load,
    input  logic [ADDR_W-1:0]    addr_load_val,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);
    logic [31:0]       enc;
    logic              enc_err;
    logic              fits12, fits13, fits21, accept;
    logic [ADDR_W-1:0] next_addr, load_addr, word_addr;

    // A signed value fits in N bits when every bit above N-2 equals the sign bit.
    assign fits12 = &in_imm[31:11] | ~|in_imm[31:11];
    assign fits13 = &in_imm[31:12] | ~|in_imm[31:12];
    assign fits21 = &in_imm[31:20] | ~|in_imm[31:20];

    always_comb begin
        enc     = 32'h0000_0013;
        enc_err = 1'b1;
        case (in_fmt)
            3'd0: begin
                enc     = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                enc_err = 1'b0;
            end
            3'd1: begin
                enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_err = !fits12;
            end
            3'd2: begin
                enc     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_err = !fits12;
            end
            3'd3: begin
                enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
                enc_err = !fits13 | in_imm[0];
            end
            3'd4: begin
                enc     = {in_imm[31:12], in_rd, in_opcode};
                enc_err = |in_imm[11:0];
            end
            3'd5: begin
                enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err = !fits21 | in_imm[0];
            end
            default: ;
        endcase
    end

    assign in_ready  = !out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign load_addr = {addr_load_val[ADDR_W-1:2], 2'b00};
    assign word_addr = addr_load ? load_addr : next_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_err    <= 1'b0;
            out_addr   <= BASE_ADDR;
            next_addr  <= BASE_ADDR;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            // Errors are counted when the flagged word leaves, not when it enters.
            if (out_valid & out_ready & out_err) begin
                err_sticky <= 1'b1;
                if (~&err_count)
                    err_count <= err_count + ERR_CNT_W'(1);
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc;
                out_err   <= enc_err;
                out_addr  <= word_addr;
                next_addr <= word_addr + ADDR_W'(4);
            end else begin
                if (out_ready)
                    out_valid <= 1'b0;
                if (addr_load)
                    next_addr <= load_addr;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of encoding, error flags, handshake and addressing.
module tb_instr_encoder;
    logic        clk, rst, addr_load, in_valid, in_ready, out_valid, out_ready, out_err, err_sticky;
    logic [31:0] addr_load_val, in_imm, out_instr, out_addr;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [7:0]  err_count;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_addr;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    instr_encoder dut (
        .clk(clk), .rst(rst), .addr_load(addr_load), .addr_load_val(addr_load_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_funct3 = v.f3;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        total += 7;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", out_instr); end
        if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", out_err); end
        if (out_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", out_addr); end
        if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b want=0", err_sticky); end
        if (err_count !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_count); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        exp_addr = 32'h0;
    endtask

    task automatic test_formats;
        vec_t v[6];
        v[0] = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0};
        v[1] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
        v[2] = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0};
        v[3] = '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        v[4] = '{3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0};
        v[5] = '{3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd1, 7'd0, 32'd8, 32'h0011_2423, 1'b0};
        out_ready = 1'b1;
        foreach (v[i]) begin
            drive(v[i]);
            step();
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL fmt%0d_valid got=%b want=1", i, out_valid); end
            if (out_instr !== v[i].instr) begin bad++; $display("FAIL fmt%0d_instr got=%h want=%h", i, out_instr, v[i].instr); end
            if (out_err !== v[i].err) begin bad++; $display("FAIL fmt%0d_err got=%b want=%b", i, out_err, v[i].err); end
            if (out_addr !== exp_addr) begin bad++; $display("FAIL fmt%0d_addr got=%h want=%h", i, out_addr, exp_addr); end
            exp_addr += 4;
        end
        in_valid = 1'b0;
        step();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL fmt_drain got=%b want=0", out_valid); end
        if (err_sticky !== 1'b0) begin bad++; $display("FAIL fmt_sticky got=%b want=0", err_sticky); end
    endtask

    task automatic test_errors;
        vec_t v[10];
        v[0] = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1};
        v[1] = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2047, 32'h7FF0_0093, 1'b0};
        v[2] = '{3'd1, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_F7FF, 32'h7FF0_0013, 1'b1};
        v[3] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3, 32'h0020_8163, 1'b1};
        v[4] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 1'b0};
        v[5] = '{3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096, 32'h8000_0063, 1'b1};
        v[6] = '{3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_1001, 32'h0000_12B7, 1'b1};
        v[7] = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0010_0000, 32'h8000_00EF, 1'b1};
        v[8] = '{3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFF0_0000, 32'h8000_00EF, 1'b0};
        v[9] = '{3'd7, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 32'h0000_0013, 1'b1};
        out_ready = 1'b1;
        foreach (v[i]) begin
            drive(v[i]);
            step();
            total += 3;
            if (out_instr !== v[i].instr) begin bad++; $display("FAIL err%0d_instr got=%h want=%h", i, out_instr, v[i].instr); end
            if (out_err !== v[i].err) begin bad++; $display("FAIL err%0d_flag got=%b want=%b", i, out_err, v[i].err); end
            if (out_addr !== exp_addr) begin bad++; $display("FAIL err%0d_addr got=%h want=%h", i, out_addr, exp_addr); end
            exp_addr += 4;
            if (i == 0) begin
                in_valid = 1'b0;
                step();
                total += 2;
                if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_first_sticky got=%b want=1", err_sticky); end
                if (err_count !== 8'd1) begin bad++; $display("FAIL err_first_count got=%0d want=1", err_count); end
            end
        end
        in_valid = 1'b0;
        step();
        total += 2;
        if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err_sticky); end
        if (err_count !== 8'd7) begin bad++; $display("FAIL err_count got=%0d want=7", err_count); end
    endtask

    task automatic test_back_to_back;
        vec_t w[3];
        w[0] = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0};
        w[1] = '{3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0};
        w[2] = '{3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 32'h0030_0193, 1'b0};
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(w[0]);
        step();
        total += 2;
        if (out_instr !== w[0].instr) begin bad++; $display("FAIL b2b_w0 got=%h want=%h", out_instr, w[0].instr); end
        if (out_addr !== 32'h0) begin bad++; $display("FAIL b2b_a0 got=%h want=0", out_addr); end
        out_ready = 1'b0;
        drive(w[1]);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready got=%b want=0", in_ready); end
        for (int c = 0; c < 2; c++) begin
            step();
            total += 4;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold%0d_ready got=%b want=0", c, in_ready); end
            if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold%0d_valid got=%b want=1", c, out_valid); end
            if (out_instr !== w[0].instr) begin bad++; $display("FAIL b2b_hold%0d_instr got=%h want=%h", c, out_instr, w[0].instr); end
            if (out_addr !== 32'h0) begin bad++; $display("FAIL b2b_hold%0d_addr got=%h want=0", c, out_addr); end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_release_ready got=%b want=1", in_ready); end
        step();
        total += 2;
        if (out_instr !== w[1].instr) begin bad++; $display("FAIL b2b_w1 got=%h want=%h", out_instr, w[1].instr); end
        if (out_addr !== 32'h4) begin bad++; $display("FAIL b2b_a1 got=%h want=4", out_addr); end
        drive(w[2]);
        step();
        total += 2;
        if (out_instr !== w[2].instr) begin bad++; $display("FAIL b2b_w2 got=%h want=%h", out_instr, w[2].instr); end
        if (out_addr !== 32'h8) begin bad++; $display("FAIL b2b_a2 got=%h want=8", out_addr); end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_addr_wrap;
        vec_t w;
        w = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0};
        out_ready = 1'b1;
        addr_load = 1'b1;
        addr_load_val = 32'hFFFF_FFFF;
        step();
        addr_load = 1'b0;
        drive(w);
        step();
        total++;
        if (out_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a0 got=%h want=fffffffc", out_addr); end
        step();
        total++;
        if (out_addr !== 32'h0) begin bad++; $display("FAIL wrap_a1 got=%h want=0", out_addr); end
        addr_load = 1'b1;
        addr_load_val = 32'h0000_0103;
        step();
        addr_load = 1'b0;
        total++;
        if (out_addr !== 32'h100) begin bad++; $display("FAIL load_accept got=%h want=100", out_addr); end
        step();
        total++;
        if (out_addr !== 32'h104) begin bad++; $display("FAIL load_next got=%h want=104", out_addr); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_stall;
        vec_t e, w;
        e = '{3'd6, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1};
        w = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0};
        out_ready = 1'b1;
        drive(e);
        step();
        total++;
        if (out_err !== 1'b1) begin bad++; $display("FAIL rs_fmt6_err got=%b want=1", out_err); end
        in_valid = 1'b0;
        step();
        total++;
        if (err_count !== 8'd1) begin bad++; $display("FAIL rs_pre_count got=%0d want=1", err_count); end
        out_ready = 1'b0;
        drive(w);
        step();
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rs_stalled got=%b want=1", out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_valid got=%b want=0", out_valid); end
        if (out_addr !== 32'h0) begin bad++; $display("FAIL rs_addr got=%h want=0", out_addr); end
        if (err_count !== 8'd0) begin bad++; $display("FAIL rs_count got=%0d want=0", err_count); end
        if (err_sticky !== 1'b0) begin bad++; $display("FAIL rs_sticky got=%b want=0", err_sticky); end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_discard got=%b want=0", out_valid); end
    endtask

    task automatic test_saturation;
        vec_t e;
        e = '{3'd7, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1};
        out_ready = 1'b1;
        drive(e);
        for (int k = 0; k < 255; k++) step();
        in_valid = 1'b0;
        step();
        total++;
        if (err_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", err_count); end
        drive(e);
        step();
        step();
        in_valid = 1'b0;
        step();
        total += 2;
        if (err_count !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", err_count); end
        if (err_sticky !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b want=1", err_sticky); end
    endtask

    initial begin
        rst = 1'b1;
        addr_load = 1'b0;
        addr_load_val = '0;
        in_valid = 1'b0;
        in_fmt = '0;
        in_opcode = '0;
        in_rd = '0;
        in_funct3 = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_funct7 = '0;
        in_imm = '0;
        out_ready = 1'b1;
        exp_addr = '0;
        test_reset();
        test_formats();
        test_errors();
        test_back_to_back();
        test_addr_wrap();
        test_reset_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
